// File: rtl/addr8u_tr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : addr8u_tr_sched                                                  |
// | Brief   : Time-redundant scheduler: three runs of one 8-bit adder, voted.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module addr8u_tr_sched #(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [8:0]       add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_sum,
  output logic             out_corr,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_RUN1 = 3'd1;
  localparam logic [2:0] c_RUN2 = 3'd2;
  localparam logic [2:0] c_RUN3 = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [7:0]       r_op_a;
  logic [7:0]       r_op_b;
  logic [8:0]       r_r1;
  logic [8:0]       r_r2;
  logic [8:0]       r_sum;
  logic             r_corr;
  logic             r_err;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_early;
  logic             w_vote_ld;
  logic [8:0]       w_sum;
  logic             w_corr;
  logic             w_err;

  // Adder operands decode from registered state only, so they never glitch with in_*.
  always_comb begin
    add_a = 8'd0;
    add_b = 8'd0;
    case (r_state)
      c_RUN1, c_RUN3: begin
        add_a = r_op_a;
        add_b = r_op_b;
      end
      c_RUN2: begin
        add_a = r_op_b;
        add_b = r_op_a;
      end
      default: ;
    endcase
  end

  assign w_early   = EARLY_EXIT && (r_state == c_RUN2) && (add_sum == r_r1);
  assign w_vote_ld = (r_state == c_RUN3);

  // Word vote; add_sum is the third run while in RUN3.
  always_comb begin
    w_sum  = r_r1;
    w_corr = 1'b0;
    w_err  = 1'b0;
    if (r_r1 == r_r2) begin
      w_corr = (add_sum != r_r1);
    end else if (r_r1 == add_sum) begin
      w_corr = 1'b1;
    end else if (r_r2 == add_sum) begin
      w_sum  = r_r2;
      w_corr = 1'b1;
    end else begin
      w_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_op_a  <= 8'd0;
      r_op_b  <= 8'd0;
      r_r1    <= 9'd0;
      r_r2    <= 9'd0;
      r_sum   <= 9'd0;
      r_corr  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_op_a  <= in_a;
            r_op_b  <= in_b;
            r_state <= c_RUN1;
          end
        end
        c_RUN1: begin
          r_r1    <= add_sum;
          r_state <= c_RUN2;
        end
        c_RUN2: begin
          r_r2 <= add_sum;
          if (w_early) begin
            r_sum   <= r_r1;
            r_corr  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= c_DONE;
          end else begin
            r_state <= c_RUN3;
          end
        end
        c_RUN3: begin
          r_sum   <= w_sum;
          r_corr  <= w_corr;
          r_err   <= w_err;
          r_state <= c_DONE;
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Saturating fault counters; clear has priority over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_corr_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_vote_ld && w_corr && !(&r_corr_cnt)) begin
        r_corr_cnt <= r_corr_cnt + c_CNT_ONE;
      end
      if (w_vote_ld && w_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + c_CNT_ONE;
      end
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign out_sum   = r_sum;
  assign out_corr  = r_corr;
  assign out_err   = r_err;
  assign corr_cnt  = r_corr_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_addr8u_tr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_addr8u_tr_sched                                               |
// | Brief   : Scoreboard bench for addr8u_tr_sched with a fault-injecting adder. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_addr8u_tr_sched;

  localparam int CW = 4;

  typedef struct packed {
    logic [8:0] sum;
    logic       corr;
    logic       err;
    logic [7:0] lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic [8:0]    add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_sum;
  logic          out_corr;
  logic          out_err;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] err_cnt;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   mode    = 0;
  int   run_idx = 0;
  int   cyc     = 0;
  exp_t q[$];
  int   acc_cyc[$];
  logic ov_d    = 1'b0;

  always #5 clk = ~clk;

  addr8u_tr_sched #(
    .EARLY_EXIT (1'b1),
    .CNT_W      (CW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_corr  (out_corr),
    .out_err   (out_err),
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt),
    .err_cnt   (err_cnt)
  );

  // Adder model: 1 = zero result on swapped 0x12/0x34, 2 = run index, 3 = flip LSB in run 2.
  always_comb begin
    add_sum = {1'b0, add_a} + {1'b0, add_b};
    if (mode == 1 && add_a == 8'h34 && add_b == 8'h12) add_sum = 9'd0;
    else if (mode == 2) add_sum = 9'(run_idx);
    else if (mode == 3 && run_idx == 2) add_sum = add_sum ^ 9'h001;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) run_idx <= 0;
    else if (in_valid && in_ready) run_idx <= 1;
    else if (run_idx != 0 && run_idx < 3) run_idx <= run_idx + 1;
    else run_idx <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare on the rising edge of out_valid, retire on handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_d) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        check("out_sum", 32'(out_sum), 32'(q[0].sum));
        check("out_corr", 32'(out_corr), 32'(q[0].corr));
        check("out_err", 32'(out_err), 32'(q[0].err));
        check("latency", 32'(cyc - acc_cyc[0] - 1), 32'(q[0].lat));
      end
    end
    ov_d <= out_valid;
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      void'(acc_cyc.pop_front());
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int t = 0;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    q.push_back(e);
    acc_cyc.push_back(cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [8:0] s, input logic c, input logic er, input int lat);
    exp_t e;
    e.sum  = s;
    e.corr = c;
    e.err  = er;
    e.lat  = 8'(lat);
    return e;
  endfunction

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int         t;
    rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_add_ab", 32'({add_a, add_b}), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_cnts", 32'({corr_cnt, err_cnt}), 32'd0);
    rst = 1'b0;

    // Carry-out corner with operand swap visible in RUN2.
    send(8'hFF, 8'h01, mk(9'h100, 1'b0, 1'b0, 2));
    check("run1_ops", 32'({add_a, add_b}), 32'h0000_FF01);
    @(negedge clk);
    check("run2_swap", 32'({add_a, add_b}), 32'h0000_01FF);
    drain();

    send(8'h00, 8'h00, mk(9'h000, 1'b0, 1'b0, 2));
    send(8'hFF, 8'hFF, mk(9'h1FE, 1'b0, 1'b0, 2));
    send(8'h80, 8'h80, mk(9'h100, 1'b0, 1'b0, 2));
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b, mk({1'b0, a} + {1'b0, b}, 1'b0, 1'b0, 2));
    end
    drain();

    // Single transient in RUN2.
    mode = 1;
    send(8'h12, 8'h34, mk(9'h046, 1'b1, 1'b0, 3));
    drain();
    check("corr_cnt_1", 32'(corr_cnt), 32'd1);
    check("err_cnt_0", 32'(err_cnt), 32'd0);

    // Three disagreeing runs.
    mode = 2;
    send(8'h05, 8'h07, mk(9'h001, 1'b0, 1'b1, 3));
    drain();
    check("err_cnt_1", 32'(err_cnt), 32'd1);
    check("corr_cnt_hold", 32'(corr_cnt), 32'd1);
    mode = 0;

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    send(8'h20, 8'h22, mk(9'h042, 1'b0, 1'b0, 2));
    t = 0;
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_sum", 32'(out_sum), 32'h042);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      in_a     = 8'h77;
      in_b     = 8'h11;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_queue", 32'(q.size()), 32'd0);

    // Reset mid-transaction drops it and clears counters.
    send(8'h03, 8'h04, mk(9'h007, 1'b0, 1'b0, 2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    acc_cyc.delete();
    check("rst_run2_idle", 32'(in_ready), 32'd1);
    check("rst_run2_valid", 32'(out_valid), 32'd0);
    check("rst_run2_cnts", 32'({corr_cnt, err_cnt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Saturate the corrected counter, then one more.
    mode = 3;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b, mk({1'b0, a} + {1'b0, b}, 1'b1, 1'b0, 3));
    end
    drain();
    check("corr_cnt_full", 32'(corr_cnt), 32'((1 << CW) - 1));
    send(8'h10, 8'h20, mk(9'h030, 1'b1, 1'b0, 3));
    drain();
    check("corr_cnt_sat", 32'(corr_cnt), 32'((1 << CW) - 1));

    // Clear coincident with the loading edge of a corrected result.
    send(8'h40, 8'h41, mk(9'h081, 1'b1, 1'b0, 3));
    @(negedge clk);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_vs_inc", 32'(corr_cnt), 32'd0);
    drain();
    check("clr_stays", 32'(corr_cnt), 32'd0);
    mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
